// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave bridging single transfers onto APB; at least 3 AHB wait states per transfer.
// Stalls AHB through HREADYOUT while APB is busy; a bounded ACCESS timeout aborts to an ERROR response.
module ahb2apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic          misaligned;
  logic          timeout_hit;
  logic [1:0]    size_q;
  logic [3:0]    strb_nxt;
  logic [CW-1:0] acc_cnt;

  assign accept = HSEL & HTRANS[1] & HREADY;

  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = HADDR[0];
      2'd2:    misaligned = |HADDR[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    strb_nxt = 4'hF;
    case (size_q)
      2'd0:    strb_nxt = 4'b0001 << PADDR[1:0];
      2'd1:    strb_nxt = PADDR[1] ? 4'b1100 : 4'b0011;
      default: strb_nxt = 4'hF;
    endcase
  end

  // acc_cnt holds (ACCESS cycle number - 1), so TO_LAST marks the final allowed cycle
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (acc_cnt == TO_LAST) && !PREADY;

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = (state == S_ERR2);
        if (accept) state_nxt = misaligned ? S_ERR1 : S_LATCH;
        else        state_nxt = S_IDLE;
      end
      S_LATCH: state_nxt = S_SETUP;
      S_SETUP: begin
        PSEL      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY)           state_nxt = PSLVERR ? S_ERR1 : S_DONE;
        else if (timeout_hit) state_nxt = S_ERR1;
      end
      S_ERR1: begin
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      size_q  <= '0;
      acc_cnt <= '0;
      HRDATA  <= '0;
    end else begin
      state <= state_nxt;
      if (HREADYOUT && accept) begin
        PADDR  <= HADDR[ADDR_WIDTH-1:0];
        PWRITE <= HWRITE;
        size_q <= HSIZE;
      end
      // HWDATA is only valid in the data phase, which is the LATCH cycle
      if (state == S_LATCH) begin
        acc_cnt <= '0;
        if (PWRITE) begin
          PWDATA <= HWDATA;
          PSTRB  <= strb_nxt;
        end else begin
          PSTRB  <= 4'h0;
        end
      end
      if (state == S_ACCESS) begin
        acc_cnt <= acc_cnt + 1'b1;
        if (PREADY && !PWRITE) HRDATA <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: expected AHB responses and APB transfers are queued by the
// stimulus and consumed by independent monitors.
module tb_ahb2apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb2apb_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct { int waits; int hcnt; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; int acc; } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // APB slave: PREADY rises after sl_waits ACCESS cycles
  int          sl_waits = 0;
  logic        sl_err   = 1'b0;
  logic [31:0] sl_rdata = '0;
  int          sl_cnt   = 0;

  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(posedge HCLK); #1;
      if (PSEL && PENABLE) begin
        PREADY  = (sl_cnt >= sl_waits);
        PSLVERR = sl_err && PREADY;
        sl_cnt++;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; sl_cnt = 0;
      end
      PRDATA = sl_rdata;
    end
  end

  // AHB response monitor
  bit   r_pend = 0;
  int   r_w = 0, r_h = 0;
  rsp_t r_e;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        r_pend = 0;
      end else begin
        if (r_pend) begin
          if (HRESP) r_h++;
          if (!HREADYOUT) r_w++;
          else begin
            r_pend = 0;
            if (rsp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rsp_unexpected: got a response, expected none (waits %0d)", r_w);
            end else begin
              r_e = rsp_q.pop_front();
              chk("rsp_waits", r_w, r_e.waits);
              chk("rsp_hresp_cycles", r_h, r_e.hcnt);
              chk("rsp_hrdata", HRDATA, r_e.rdata);
            end
          end
        end
        if (HSEL && HTRANS[1] && HREADY) begin
          r_pend = 1; r_w = 0; r_h = 0;
        end
      end
    end
  end

  // APB transfer monitor
  bit          a_act = 0, a_stable = 0;
  int          a_acc = 0;
  logic [68:0] a_cap;
  apb_t        a_e;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        a_act = 0;
      end else if (PSEL) begin
        if (!PENABLE) begin
          a_act = 1; a_acc = 0; a_stable = 1;
          a_cap = {PADDR, PWRITE, PWDATA, PSTRB};
        end else begin
          a_acc++;
          if ({PADDR, PWRITE, PWDATA, PSTRB} !== a_cap) a_stable = 0;
        end
      end else if (a_act) begin
        a_act = 0;
        if (apb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL apb_unexpected: got transfer at 0x%08h, expected none", a_cap[68:37]);
        end else begin
          a_e = apb_q.pop_front();
          chk("apb_paddr", a_cap[68:37], a_e.addr);
          chk("apb_pwrite", {31'b0, a_cap[36]}, {31'b0, a_e.wr});
          if (a_e.wr) chk("apb_pwdata", a_cap[35:4], a_e.wdata);
          chk("apb_pstrb", {28'b0, a_cap[3:0]}, {28'b0, a_e.strb});
          chk("apb_access_cycles", a_acc, a_e.acc);
          chk("apb_stable", {31'b0, a_stable}, 32'd1);
        end
      end
    end
  end

  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [31:0] wdata);
    int n;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    n = 0;
    do begin
      @(negedge HCLK); n++;
    end while (!HREADYOUT && n < 64);
    if (!HREADYOUT) begin
      checks++; errors++;
      $display("FAIL accept_timeout: HREADYOUT still 0 after %0d cycles", n);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge HCLK); n++;
    end while (!HREADYOUT && n < 64);
    if (!HREADYOUT) begin
      checks++; errors++;
      $display("FAIL done_timeout: HREADYOUT still 0 after %0d cycles", n);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, {31'b0, HREADYOUT}, 32'd1);
    chk({tag, "_hresp"}, {31'b0, HRESP}, 32'd0);
    chk({tag, "_hrdata"}, HRDATA, 32'd0);
    chk({tag, "_psel"}, {31'b0, PSEL}, 32'd0);
    chk({tag, "_penable"}, {31'b0, PENABLE}, 32'd0);
    chk({tag, "_pwrite"}, {31'b0, PWRITE}, 32'd0);
    chk({tag, "_paddr"}, PADDR, 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_pstrb"}, {28'b0, PSTRB}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_rd;

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
    HTRANS = '0; HWDATA = '0; exp_rd = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk_reset_vals("reset");
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // BUSY with a misaligned-looking address: zero wait, no APB activity
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h13; HSIZE = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("busy_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      chk("busy_hresp", {31'b0, HRESP}, 32'd0);
      chk("busy_psel", {31'b0, PSEL}, 32'd0);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;

    // word write, zero-wait APB
    sl_waits = 0;
    rsp_q.push_back(rsp_t'{3, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h10, 1'b1, 32'h1234_5678, 4'hF, 1});
    ahb_xfer(32'h10, 1'b1, 2'd2, 32'h1234_5678);
    wait_done();

    // byte read, two PREADY-low cycles
    sl_waits = 2; sl_rdata = 32'hA5A5_A5A5; exp_rd = 32'hA5A5_A5A5;
    rsp_q.push_back(rsp_t'{5, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h103, 1'b0, 32'h0, 4'h0, 3});
    ahb_xfer(32'h103, 1'b0, 2'd0, 32'h0);
    wait_done();

    // aligned half-word write at offset 2
    sl_waits = 0;
    rsp_q.push_back(rsp_t'{3, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h22, 1'b1, 32'hBEEF_0000, 4'hC, 1});
    ahb_xfer(32'h22, 1'b1, 2'd1, 32'hBEEF_0000);
    wait_done();

    // misaligned half-word write: ERROR without APB
    rsp_q.push_back(rsp_t'{1, 2, exp_rd});
    ahb_xfer(32'h21, 1'b1, 2'd1, 32'h1);
    wait_done();

    // read completing with PSLVERR still returns data
    sl_err = 1'b1; sl_rdata = 32'hDEAD_BEEF; exp_rd = 32'hDEAD_BEEF;
    rsp_q.push_back(rsp_t'{4, 2, exp_rd});
    apb_q.push_back(apb_t'{32'h30, 1'b0, 32'h0, 4'h0, 1});
    ahb_xfer(32'h30, 1'b0, 2'd2, 32'h0);
    wait_done();
    sl_err = 1'b0;

    // byte write, PREADY on the last ACCESS cycle before timeout
    sl_waits = 3;
    rsp_q.push_back(rsp_t'{6, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h41, 1'b1, 32'h0000_AB00, 4'h2, 4});
    ahb_xfer(32'h41, 1'b1, 2'd0, 32'h0000_AB00);
    wait_done();

    // hung peripheral: timeout after 4 ACCESS cycles
    sl_waits = 100;
    rsp_q.push_back(rsp_t'{7, 2, exp_rd});
    apb_q.push_back(apb_t'{32'h50, 1'b1, 32'h1, 4'hF, 4});
    ahb_xfer(32'h50, 1'b1, 2'd2, 32'h1);
    wait_done();

    // HSIZE=3 is always illegal
    sl_waits = 0;
    rsp_q.push_back(rsp_t'{1, 2, exp_rd});
    ahb_xfer(32'h60, 1'b0, 2'd3, 32'h0);
    wait_done();

    // back-to-back writes, reset during the second ACCESS
    sl_waits = 1;
    rsp_q.push_back(rsp_t'{4, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h70, 1'b1, 32'h11, 4'hF, 2});
    ahb_xfer(32'h70, 1'b1, 2'd2, 32'h11);
    ahb_xfer(32'h74, 1'b1, 2'd2, 32'h22);
    @(negedge HCLK);
    chk("b2b_latch_psel", {31'b0, PSEL}, 32'd0);
    chk("b2b_latch_hreadyout", {31'b0, HREADYOUT}, 32'd0);
    @(negedge HCLK);
    chk("b2b_setup_psel", {31'b0, PSEL}, 32'd1);
    chk("b2b_setup_penable", {31'b0, PENABLE}, 32'd0);
    chk("b2b_setup_paddr", PADDR, 32'h74);
    @(negedge HCLK);
    chk("b2b_access_penable", {31'b0, PENABLE}, 32'd1);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    chk_reset_vals("midreset");
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    exp_rd = '0;

    // bridge is usable again after the abort
    sl_waits = 0; sl_rdata = 32'h0BAD_F00D; exp_rd = 32'h0BAD_F00D;
    rsp_q.push_back(rsp_t'{3, 0, exp_rd});
    apb_q.push_back(apb_t'{32'h80, 1'b0, 32'h0, 4'h0, 1});
    ahb_xfer(32'h80, 1'b0, 2'd2, 32'h0);
    wait_done();

    repeat (5) @(posedge HCLK);
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    chk("apb_queue_empty", apb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-lite slave that converts single AHB transfers into APB3/APB4 transfers for the low-speed peripheral bus. It sits directly downstream of the system's AHB address decoder and response multiplexer. The bridge receives its select from the decoder, returns HREADYOUT, HRESP and HRDATA to the multiplexer, and is the only master on the APB side. It also enforces alignment and applies an APB timeout so that a hung peripheral cannot stall the AHB bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PADDR; equal to HADDR[ADDR_WIDTH-1:0]
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before abort; 0 disables the timeout

Ports:
- HCLK  in  1  single clock for both sides
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  bridge selected, from the decoder
- HADDR  in  32  AHB address
- HWRITE  in  1  1 = write
- HSIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready, from the multiplexer
- HREADYOUT  out  1  bridge ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB byte strobes; 0 on reads
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- A transfer is accepted when HSEL & HTRANS[1] & HREADY. On accept the bridge registers HADDR, HWRITE and HSIZE.
- IDLE and BUSY transfers get an OKAY response with zero wait states, and cause no state change.

State machine states: IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: on accept, go to LATCH if the transfer is aligned, otherwise to ERR1.
- LATCH: capture HWDATA, then go to SETUP.
- SETUP: go to ACCESS.
- ACCESS:
  - PREADY & !PSLVERR: go to DONE.
  - PREADY & PSLVERR: go to ERR1.
  - !PREADY: stay in ACCESS, unless the timeout fires; then go to ERR1.
- DONE: on accept, go to LATCH or ERR1 as from IDLE; otherwise go to IDLE.
- ERR1: go to ERR2.
- ERR2: on accept, go to LATCH or ERR1 as from IDLE; otherwise go to IDLE.

Outputs per state:
- HREADYOUT = 1 in IDLE, DONE and ERR2; 0 in every other state.
- HRESP = 1 in ERR1 and ERR2 only.
- PSEL = 1 in SETUP and ACCESS.
- PENABLE = 1 in ACCESS.
- PADDR, PWRITE, PWDATA and PSTRB are registered and held stable through SETUP and ACCESS.

Alignment:
- A transfer is misaligned when HSIZE=3, when HSIZE=1 with HADDR[0]=1, or when HSIZE=2 with HADDR[1:0]≠0.
- A misaligned transfer never reaches APB: PSEL stays 0 and the bridge returns a two-cycle ERROR.

PSTRB on writes:
- byte: 1 << HADDR[1:0]
- half: 4'b0011 << (2·HADDR[1])
- word: 4'hF

Read data:
- HRDATA ← PRDATA on the completing ACCESS cycle of a read, including a PSLVERR completion.
- HRDATA holds its value otherwise; writes leave it unchanged.

Timeout counter:
- Counts ACCESS cycles and is cleared on entry to SETUP.
- If TIMEOUT_CYCLES≠0 and ACCESS cycle number TIMEOUT_CYCLES sees PREADY=0, the bridge aborts to ERR1.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0; state IDLE.
- HRESET asserted in any state, including mid-ACCESS, forces the reset values on the next edge. The aborted transfer gets no response.
- Zero-wait APB transfer with accept in cycle A:
  - A+1 LATCH, A+2 SETUP, A+3 ACCESS.
  - A+4 DONE with HREADYOUT=1.
  - AHB sees 3 wait states.
- Each cycle of PREADY=0 in ACCESS adds one wait state.
- ERROR response: ERR1 drives HREADYOUT=0/HRESP=1, then ERR2 drives HREADYOUT=1/HRESP=1. This is the standard two-cycle AHB error.
- Misaligned accept in cycle A: ERR1 at A+1, ERR2 at A+2.
- Back-to-back transfers: the next address phase is accepted during DONE or ERR2. LATCH follows immediately, so there is no IDLE gap.
- No address phase can be accepted while HREADYOUT=0, because HREADY is then low.

## Test plan
- Write word 0x1234_5678 to 0x0000_0010, PREADY tied 1:
  - APB shows SETUP/ACCESS with PADDR=0x10, PWDATA=0x12345678, PSTRB=4'hF.
  - HREADYOUT is low for 3 cycles; HRESP=0.
- Read byte from 0x...03 with PREADY low for 2 ACCESS cycles and PRDATA=0xA5A5_A5A5:
  - PSTRB=0; AHB sees 5 wait states; HRDATA=0xA5A5A5A5 in DONE.
- Half-word write at address 0x...02:
  - PSTRB=4'b1100.
- Half-word write at address 0x...01:
  - PSEL never asserts; ERR1 then ERR2.
- Read with PSLVERR=1 on the completing ACCESS cycle:
  - HRESP=1 for 2 cycles, with HREADYOUT 0 then 1.
- TIMEOUT_CYCLES=4, PREADY held 0:
  - Exactly 4 ACCESS cycles, then PSEL/PENABLE drop and ERROR is returned.
- Two NONSEQ writes back to back, then HRESET pulsed during the second transfer's ACCESS:
  - Second SETUP follows the first DONE by 2 cycles (LATCH, then SETUP).
  - After reset all outputs return to their reset values.
